rot_shift_sched: RTL

ROT_SHIFT_SCHED -- requirements
Module: rot_shift_sched

---
 rtl/rot_shift_sched_pkg.sv | 24 ++
 rtl/rot_shift_sched_rot_reg.sv | 30 +++
 rtl/rot_shift_sched.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rot_shift_sched_pkg.sv
// Shared definitions for the rotating-register scheduler: op encoding,
// FSM state encoding and reset constants.
package rot_shift_sched_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ROTL = 2'b10,
    OP_ROTR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Register comes out of reset with only the LSB set.
  localparam int unsigned RST_COUNT = 1;

  // Last-grant pointer resets to requester 1 so requester 0 wins the first tie.
  localparam logic RST_LAST_GRANT = 1'b1;

endpackage

// File: rtl/rot_shift_sched_rot_reg.sv
// rot_reg: WIDTH-bit register with load / rotate-left / rotate-right / hold.
// Load has priority over the rotate controls; async reset to RST_COUNT.
module rot_reg
  import rot_shift_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             rotl,
  input  logic             rotr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value
);

  // Register update: one operation per cycle, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= WIDTH'(RST_COUNT);
    end else if (load) begin
      value <= data;
    end else if (rotl) begin
      value <= {value[WIDTH-2:0], value[WIDTH-1]};
    end else if (rotr) begin
      value <= {value[0], value[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/rot_shift_sched.sv
// rot_shift_sched: two-requester scheduler driving a rotating register.
// FSM IDLE -> EXEC -> DONE -> IDLE plus a requester arbiter; the register
// itself lives in rot_reg.
// Optional macro ROT_SHIFT_SCHED_FIXED_PRIO_EN: requester 0 always wins ties
// and no last-grant pointer exists; otherwise ties are round-robin.
//
// Handshake: req_ready is combinational, only in IDLE, one-hot on the granted
// requester among those with req_valid=1. A command is accepted on a rising
// edge where req_valid[i] & req_ready[i]; the other requester's inputs are
// ignored until it is granted.
module rot_shift_sched
  import rot_shift_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [3:0]           req_op,
  input  logic [2*AMT_W-1:0]   req_amt,
  input  logic [2*WIDTH-1:0]   req_data,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output state_t               dbg_state
);

  state_t             state;
  op_t                cur_op;
  logic [AMT_W-1:0]   remaining;
  logic [WIDTH-1:0]   cur_data;
  logic               cur_id;

  logic               grant_id;
  logic               handshake;
  logic [1:0]         sel_op;
  logic [AMT_W-1:0]   sel_amt;
  logic [WIDTH-1:0]   sel_data;

  logic               exec;
  logic               step;
  logic               reg_load;
  logic               reg_rotl;
  logic               reg_rotr;

`ifndef ROT_SHIFT_SCHED_FIXED_PRIO_EN
  logic               last_grant;
`endif

  assign dbg_state = state;

  // Arbiter: pick the requester to serve and raise its ready while IDLE.
  always_comb begin
    grant_id = 1'b0;
`ifdef ROT_SHIFT_SCHED_FIXED_PRIO_EN
    grant_id = ~req_valid[0];
`else
    if (&req_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req_valid[1];
    end
`endif
    req_ready = 2'b00;
    if ((state == ST_IDLE) && !reset && (|req_valid)) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign handshake = |(req_valid & req_ready);
  assign sel_op    = grant_id ? req_op[3:2] : req_op[1:0];
  assign sel_amt   = grant_id ? req_amt[2*AMT_W-1:AMT_W] : req_amt[AMT_W-1:0];
  assign sel_data  = grant_id ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];

  // Register controls decoded from the latched command while executing.
  always_comb begin
    exec     = (state == ST_EXEC);
    step     = exec && (remaining != '0) &&
               ((cur_op == OP_ROTL) || (cur_op == OP_ROTR));
    reg_load = exec && (cur_op == OP_LOAD);
    reg_rotl = step && (cur_op == OP_ROTL);
    reg_rotr = step && (cur_op == OP_ROTR);
  end

  // Scheduler FSM: accept a command, step it to completion, pulse done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_op     <= OP_NOP;
      remaining  <= '0;
      cur_data   <= '0;
      cur_id     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
`ifndef ROT_SHIFT_SCHED_FIXED_PRIO_EN
      last_grant <= RST_LAST_GRANT;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            cur_op     <= op_t'(sel_op);
            remaining  <= sel_amt;
            cur_data   <= sel_data;
            cur_id     <= grant_id;
            busy       <= 1'b1;
            state      <= ST_EXEC;
`ifndef ROT_SHIFT_SCHED_FIXED_PRIO_EN
            last_grant <= grant_id;
`endif
          end
        end
        ST_EXEC: begin
          if (step) begin
            remaining <= remaining - AMT_W'(1);
          end
          // Non-rotating commands and amt=0 finish after one cycle; rotations
          // finish on the edge that applies their last step.
          if (!step || (remaining == AMT_W'(1))) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            done_id <= cur_id;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  rot_reg #(
    .WIDTH(WIDTH)
  ) u_rot_reg (
    .clock(clock),
    .reset(reset),
    .load (reg_load),
    .rotl (reg_rotl),
    .rotr (reg_rotr),
    .data (cur_data),
    .value(count)
  );

endmodule
